mem_access_ctrl: RTL and testbench

MEM-stage data-memory access controller of the 5-stage MIPS pipeline: the producer side of the MEM/WB boundary. It decodes the load/store in the MEM stage and runs a req/ack handshake with the data-memory bus. Meanwhile it stalls the pipeline, then presents the raw read word (`ReadDataM`) and the byte offset (`MemAddrM`) that MEM/WB carries forward. Sub-word extraction and sign extension stay in the WB stage.

---
 rtl/mips_mem_pkg.sv | 56 +++++
 rtl/mem_lane_gen.sv | 35 +++
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access path.
// Contents: load/store opcodes, FSM state enum, access-size encoding,
// the bus error fill word, decoded-op and bus-request payload structs,
// and the opcode decoder helper.
package mips_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [XLEN-1:0] DEAD_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        size_e size;
    } mem_dec_t;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    // Opcode -> memory-op class and access size; anything else is a no-op.
    function automatic mem_dec_t decode_op(input logic [5:0] op);
        mem_dec_t d;
        d.is_mem  = 1'b1;
        d.is_load = 1'b1;
        d.size    = SZ_W;
        case (op)
            OP_LB, OP_LBU: d.size = SZ_B;
            OP_LH, OP_LHU: d.size = SZ_H;
            OP_LW:         d.size = SZ_W;
            OP_SB: begin d.is_load = 1'b0; d.size = SZ_B; end
            OP_SH: begin d.is_load = 1'b0; d.size = SZ_H; end
            OP_SW: begin d.is_load = 1'b0; d.size = SZ_W; end
            default: begin d.is_mem = 1'b0; d.is_load = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// Little-endian byte-lane generator for data-memory stores.
// Ports: size_i (access size), off_i (addr[1:0]), wd_i (store data),
//        be_o (byte enables), wdata_o (lane-replicated data),
//        misalign_o (offset illegal for the size).
module mem_lane_gen
    import mips_mem_pkg::*;
(
    input  size_e           size_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misalign_o
);

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wd_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wd_i[7:0]}};
            end
            SZ_H: begin
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{wd_i[15:0]}};
                misalign_o = off_i[0];
            end
            SZ_W:    misalign_o = |off_i;
            default: misalign_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: decodes the MEM-stage load/store,
// runs the req/ack bus handshake while stalling the pipeline, and presents
// the raw read word plus byte offset to MEM/WB.
// Ports: clk, rst (async, active-high); instrM/ALUOutM/WriteDataM from MEM;
//        stallM, ReadDataM, MemAddrM, misalignM, mem_err to the pipeline;
//        bus_req/bus_we/bus_addr/bus_be/bus_wdata/bus_rdata/bus_ack to memory.
// Optional: define MEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT cycles
// without ack (pulses mem_err, returns DEAD_WORD).
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instrM,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            stallM,
    output logic [XLEN-1:0] ReadDataM,
    output logic [1:0]      MemAddrM,
    output logic            misalignM,
    output logic            mem_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack
);

    mem_dec_t        dec;
    logic [BE_W-1:0] lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic            lane_mis;
    logic            go_c;
    logic            stall_c;
    state_e          state_q, state_d;
    bus_req_t        req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            unused_instr;

    assign dec          = decode_op(instrM[31:26]);
    assign unused_instr = ^instrM[25:0];

    mem_lane_gen u_lane (
        .size_i     (dec.size),
        .off_i      (ALUOutM[1:0]),
        .wd_i       (WriteDataM),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .misalign_o (lane_mis)
    );

    assign MemAddrM  = ALUOutM[1:0];
    assign misalignM = dec.is_mem & lane_mis;
    assign go_c      = dec.is_mem & ~lane_mis;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expire_c;

    // Last BUSY cycle allowed before the access is abandoned.
    assign expire_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign mem_err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
    assign mem_err        = 1'b0;
`endif

    // Stall is combinational in IDLE so the op is held the cycle it appears.
    assign stallM    = stall_c & ~rst;
    assign ReadDataM = rdata_q;
    assign bus_req   = req_q.valid;
    assign bus_we    = req_q.we;
    assign bus_addr  = req_q.addr;
    assign bus_be    = req_q.be;
    assign bus_wdata = req_q.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state, bus request payload and read-word capture.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
                if (go_c) begin
                    stall_c     = 1'b1;
                    state_d     = ST_BUSY;
                    req_d.valid = 1'b1;
                    req_d.we    = ~dec.is_load;
                    req_d.addr  = {ALUOutM[31:2], 2'b00};
                    req_d.be    = dec.is_load ? 4'b1111 : lane_be;
                    req_d.wdata = dec.is_load ? '0 : lane_wdata;
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    state_d = ST_DONE;
                    req_d   = '0;
                    rdata_d = req_q.we ? '0 : bus_rdata;
                end
`ifdef MEM_TIMEOUT_EN
                else if (expire_c) begin
                    state_d = ST_DONE;
                    req_d   = '0;
                    rdata_d = DEAD_WORD;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// reset/timeout sequences and randomized ops against a behavioural model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrM, ALUOutM, WriteDataM, bus_rdata;
    logic        bus_ack;
    logic        stallM, misalignM, mem_err, bus_req, bus_we;
    logic [31:0] ReadDataM, bus_addr, bus_wdata;
    logic [1:0]  MemAddrM;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          waits;
        bit          mem;
        bit          mis;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .instrM     (instrM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .stallM     (stallM),
        .ReadDataM  (ReadDataM),
        .MemAddrM   (MemAddrM),
        .misalignM  (misalignM),
        .mem_err    (mem_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                                input bit mem, input bit mis, input bit we, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rd);
        vec_t v;
        v.name = nm; v.op = op; v.addr = addr; v.wd = wd; v.rdata = rdata; v.waits = waits;
        v.mem = mem; v.mis = mis; v.we = we; v.be = be; v.wdata = wdata; v.rd = rd;
        return v;
    endfunction

    // Reference model: access width in bytes, alignment by modulo, lanes by arithmetic.
    function automatic vec_t model(input logic [5:0] op, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rdata, input int waits);
        vec_t v;
        int   n;
        bit   ld;
        int   off;
        n = 0; ld = 0;
        case (op)
            6'h20, 6'h24: begin n = 1; ld = 1; end
            6'h21, 6'h25: begin n = 2; ld = 1; end
            6'h23:        begin n = 4; ld = 1; end
            6'h28:        n = 1;
            6'h29:        n = 2;
            6'h2B:        n = 4;
            default:      n = 0;
        endcase
        off = int'(addr % 4);
        v.name = "rand"; v.op = op; v.addr = addr; v.wd = wd; v.rdata = rdata; v.waits = waits;
        v.mem   = (n != 0);
        v.mis   = v.mem && ((off % n) != 0);
        v.we    = !ld;
        v.be    = ld ? 4'hF : 4'(((1 << n) - 1) << off);
        v.wdata = (n == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                  (n == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
        v.rd    = (v.mem && !v.mis && ld) ? rdata : 32'h0;
        return v;
    endfunction

    // Drives one op starting in IDLE and checks every cycle until it leaves MEM.
    task automatic run_op(input vec_t v);
        int stall_cnt;
        bit go;
        go = v.mem && !v.mis;
        stall_cnt = 0;
        instrM = {v.op, 26'h0};
        ALUOutM = v.addr;
        WriteDataM = v.wd;
        bus_ack = 1'b0;
        @(negedge clk);
        chk({v.name, " idle stall"}, 32'(stallM), 32'(go));
        chk({v.name, " idle misalign"}, 32'(misalignM), 32'(v.mis));
        chk({v.name, " idle memaddr"}, 32'(MemAddrM), 32'(v.addr[1:0]));
        chk({v.name, " idle req"}, 32'(bus_req), 32'h0);
        chk({v.name, " idle rdata"}, ReadDataM, 32'h0);
        if (stallM) stall_cnt++;
        @(posedge clk); #1;
        if (!go) begin
            @(negedge clk);
            chk({v.name, " hold req"}, 32'(bus_req), 32'h0);
            chk({v.name, " hold stall"}, 32'(stallM), 32'h0);
            chk({v.name, " hold rdata"}, ReadDataM, 32'h0);
            @(posedge clk); #1;
            return;
        end
        for (int w = 0; w <= v.waits; w++) begin
            if (w == v.waits) begin
                bus_ack = 1'b1;
                bus_rdata = v.rdata;
            end else begin
                bus_rdata = $urandom;
            end
            @(negedge clk);
            chk({v.name, " busy req"}, 32'(bus_req), 32'h1);
            chk({v.name, " busy we"}, 32'(bus_we), 32'(v.we));
            chk({v.name, " busy addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
            chk({v.name, " busy be"}, 32'(bus_be), 32'(v.be));
            if (v.we) chk({v.name, " busy wdata"}, bus_wdata, v.wdata);
            chk({v.name, " busy rdata"}, ReadDataM, 32'h0);
            chk({v.name, " busy err"}, 32'(mem_err), 32'h0);
            if (stallM) stall_cnt++;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        @(negedge clk);
        chk({v.name, " done stall"}, 32'(stallM), 32'h0);
        chk({v.name, " done req"}, 32'(bus_req), 32'h0);
        chk({v.name, " done rdata"}, ReadDataM, v.rd);
        chk({v.name, " done err"}, 32'(mem_err), 32'h0);
        chk({v.name, " stall cycles"}, 32'(stall_cnt), 32'(v.waits + 2));
        @(posedge clk); #1;
    endtask

    logic [5:0] ops [11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h00, 6'h08, 6'h0F};

    initial begin
        vecs.push_back(mk("lw_zw",   6'h23, 32'h100,  32'h0,        32'h12345678, 0, 1, 0, 0, 4'hF, 32'h0,        32'h12345678));
        vecs.push_back(mk("sb_w2",   6'h28, 32'h203,  32'h000000AB, 32'h5555AAAA, 2, 1, 0, 1, 4'h8, 32'hABABABAB, 32'h0));
        vecs.push_back(mk("lh_mis",  6'h21, 32'h101,  32'h0,        32'h0,        0, 1, 1, 0, 4'hF, 32'h0,        32'h0));
        vecs.push_back(mk("sh_b2b",  6'h29, 32'h12,   32'h00001234, 32'h0,        1, 1, 0, 1, 4'hC, 32'h12341234, 32'h0));
        vecs.push_back(mk("lbu_b2b", 6'h24, 32'h13,   32'h0,        32'hCAFE00FF, 0, 1, 0, 0, 4'hF, 32'h0,        32'hCAFE00FF));
        vecs.push_back(mk("addi",    6'h08, 32'h2,    32'h0,        32'h0,        0, 0, 0, 1, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("lw_mis",  6'h23, 32'h102,  32'h0,        32'h0,        0, 1, 1, 0, 4'hF, 32'h0,        32'h0));
        vecs.push_back(mk("sw_mis",  6'h2B, 32'h201,  32'h0,        32'h0,        0, 1, 1, 1, 4'hF, 32'h0,        32'h0));
        vecs.push_back(mk("sw_w1",   6'h2B, 32'h400,  32'h89ABCDEF, 32'h0,        1, 1, 0, 1, 4'hF, 32'h89ABCDEF, 32'h0));
        vecs.push_back(mk("lhu_w3",  6'h25, 32'h22,   32'h0,        32'h0F0F1234, 3, 1, 0, 0, 4'hF, 32'h0,        32'h0F0F1234));
        vecs.push_back(mk("sh_mis",  6'h29, 32'h11,   32'h0,        32'h0,        0, 1, 1, 1, 4'hF, 32'h0,        32'h0));
        vecs.push_back(mk("sb_off0", 6'h28, 32'h1000, 32'hFFFFFF5A, 32'h0,        0, 1, 0, 1, 4'h1, 32'h5A5A5A5A, 32'h0));
        vecs.push_back(mk("sh_off2", 6'h29, 32'h2E,   32'hBEEF7777, 32'h0,        0, 1, 0, 1, 4'hC, 32'h77777777, 32'h0));
        vecs.push_back(mk("lb",      6'h20, 32'h7,    32'h0,        32'h00000080, 0, 1, 0, 0, 4'hF, 32'h0,        32'h00000080));

        // Reset state: outputs low, offset and misalign follow inputs.
        rst = 1'b1;
        instrM = {6'h23, 26'h0};
        ALUOutM = 32'h0000_0103;
        WriteDataM = 32'h0;
        bus_rdata = 32'h0;
        bus_ack = 1'b0;
        #12;
        chk("rst stall", 32'(stallM), 32'h0);
        chk("rst req", 32'(bus_req), 32'h0);
        chk("rst err", 32'(mem_err), 32'h0);
        chk("rst rdata", ReadDataM, 32'h0);
        chk("rst we", 32'(bus_we), 32'h0);
        chk("rst be", 32'(bus_be), 32'h0);
        chk("rst addr", bus_addr, 32'h0);
        chk("rst wdata", bus_wdata, 32'h0);
        chk("rst memaddr", 32'(MemAddrM), 32'h3);
        chk("rst misalign", 32'(misalignM), 32'h1);
        instrM = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors, issued back to back.
        foreach (vecs[i]) run_op(vecs[i]);

        // Reset in the second BUSY cycle, then a stray ack after release.
        instrM = {6'h2B, 26'h0};
        ALUOutM = 32'h40;
        WriteDataM = 32'h11223344;
        @(negedge clk);
        chk("rmid idle stall", 32'(stallM), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid busy1 req", 32'(bus_req), 32'h1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rmid req", 32'(bus_req), 32'h0);
        chk("rmid stall", 32'(stallM), 32'h0);
        chk("rmid rdata", ReadDataM, 32'h0);
        chk("rmid be", 32'(bus_be), 32'h0);
        @(posedge clk); #1;
        instrM = 32'h0;
        rst = 1'b0;
        @(negedge clk);
        chk("rmid post stall", 32'(stallM), 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late ack req", 32'(bus_req), 32'h0);
        chk("late ack stall", 32'(stallM), 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late ack rdata", ReadDataM, 32'h0);
        chk("late ack req2", 32'(bus_req), 32'h0);
        @(posedge clk); #1;
        run_op(model(6'h23, 32'h44, 32'h0, 32'hA5A5_0001, 0));

        // Access that never gets an ack.
        instrM = {6'h23, 26'h0};
        ALUOutM = 32'h300;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("noack idle stall", 32'(stallM), 32'h1);
        @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("to busy req", 32'(bus_req), 32'h1);
            chk("to busy err", 32'(mem_err), 32'h0);
            chk("to busy stall", 32'(stallM), 32'h1);
            @(posedge clk); #1;
        end
        instrM = 32'h0;
        @(negedge clk);
        chk("to done err", 32'(mem_err), 32'h1);
        chk("to done req", 32'(bus_req), 32'h0);
        chk("to done rdata", ReadDataM, 32'hDEADBEEF);
        chk("to done stall", 32'(stallM), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to after err", 32'(mem_err), 32'h0);
        chk("to after rdata", ReadDataM, 32'h0);
        @(posedge clk); #1;
`else
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("noack stall", 32'(stallM), 32'h1);
            chk("noack err", 32'(mem_err), 32'h0);
            chk("noack req", 32'(bus_req), 32'h1);
            @(posedge clk); #1;
        end
        instrM = 32'h0;
        rst = 1'b1;
        #1;
        chk("noack rst req", 32'(bus_req), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        // Randomized ops against the model.
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  op;
            logic [31:0] addr;
            op = ops[$urandom_range(0, 10)];
            addr = $urandom;
            run_op(model(op, addr, $urandom, $urandom, int'($urandom_range(0, 3))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
